// File: rtl/ray_pkg.sv
// Shared types for the pixel ray scheduler: frame defaults, coordinate and
// result records, and the scheduler FSM encoding.
package ray_pkg;
  localparam int H_PIXELS_DFLT = 512;
  localparam int V_PIXELS_DFLT = 384;
  localparam int X_W = 11;
  localparam int Y_W = 10;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pixel_coord_t;

  typedef struct packed {
    pixel_coord_t coord;
    logic [31:0]  dir_x;
    logic [31:0]  dir_y;
    logic [31:0]  dir_z;
  } ray_result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } sched_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/pixel_ray_scheduler.sv
// Raster-order pixel issuer for eye_to_pixel; re-tags returned directions with
// their pixel coordinate and buffers them under credit-based flow control.
module pixel_ray_scheduler
  import ray_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DFLT,
  parameter int V_PIXELS = V_PIXELS_DFLT,
  parameter int DEPTH    = 16
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           start_in,
  output logic           busy_out,
  output logic           frame_done_out,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           valid_out,
  input  logic [31:0]    dir_x_in,
  input  logic [31:0]    dir_y_in,
  input  logic [31:0]    dir_z_in,
  input  logic           dir_valid_in,
  output logic [X_W-1:0] ray_x_out,
  output logic [Y_W-1:0] ray_y_out,
  output logic [31:0]    ray_dir_x_out,
  output logic [31:0]    ray_dir_y_out,
  output logic [31:0]    ray_dir_z_out,
  output logic           ray_valid_out,
  input  logic           ray_ready_in,
  output logic           err_out
);
  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_t   state, state_nxt;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic [CW-1:0]  in_use;
  logic           issue, pop, last_pix;

  pixel_coord_t   tag_in, tag_head;
  logic           tag_push, tag_pop, tag_full, tag_empty;
  ray_result_t    res_in, res_head, res_shown;
  logic           res_push, res_full, res_empty, dir_ok;

  // A credit covers a ray from issue until its result is popped, so neither
  // FIFO can overflow while in_use is capped at DEPTH.
  assign issue    = (state == ST_ISSUE) && (in_use < CW'(DEPTH));
  assign pop      = ray_valid_out & ray_ready_in;
  assign last_pix = (x_cnt == X_W'(H_PIXELS-1)) && (y_cnt == Y_W'(V_PIXELS-1));
  assign busy_out = (state != ST_IDLE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    frame_done_out = 1'b0;
    case (state)
      ST_IDLE:  if (start_in) state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue && last_pix) state_nxt = ST_DRAIN;
      ST_DRAIN: if (in_use == '0) begin
        state_nxt      = ST_IDLE;
        frame_done_out = 1'b1;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      x_out     <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= issue;
      if (issue) begin
        x_out <= x_cnt;
        y_out <= y_cnt;
        if (x_cnt == X_W'(H_PIXELS-1)) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_W'(V_PIXELS-1)) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end else if (state == ST_IDLE) begin
        x_out <= '0;
        y_out <= '0;
        if (start_in) begin
          x_cnt <= '0;
          y_cnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      in_use <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   in_use <= in_use + 1'b1;
        2'b01:   in_use <= in_use - 1'b1;
        default: in_use <= in_use;
      endcase
    end
  end

  // Tag enters the FIFO in the cycle its coordinate is presented downstream.
  assign tag_in   = '{x: x_out, y: y_out};
  assign tag_push = valid_out & ~tag_full;
  assign dir_ok   = ~tag_empty & ~res_full;
  assign tag_pop  = dir_valid_in & dir_ok;
  assign res_push = tag_pop;
  assign res_in   = {tag_head, dir_x_in, dir_y_in, dir_z_in};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                    err_out <= 1'b0;
    else if (dir_valid_in && !dir_ok) err_out <= 1'b1;
  end

  sync_fifo #(.WIDTH($bits(pixel_coord_t)), .DEPTH(DEPTH)) u_tag_fifo (
    .gclk      (clk_in),
    .grst_n    (rst_n_in),
    .push      (tag_push),
    .push_data (tag_in),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  sync_fifo #(.WIDTH($bits(ray_result_t)), .DEPTH(DEPTH)) u_res_fifo (
    .gclk      (clk_in),
    .grst_n    (rst_n_in),
    .push      (res_push),
    .push_data (res_in),
    .pop       (pop),
    .pop_data  (res_head),
    .full      (res_full),
    .empty     (res_empty)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  assign ray_valid_out = ~res_empty;
  assign res_shown     = res_empty ? '0 : res_head;
  assign ray_x_out     = res_shown.coord.x;
  assign ray_y_out     = res_shown.coord.y;
  assign ray_dir_x_out = res_shown.dir_x;
  assign ray_dir_y_out = res_shown.dir_y;
  assign ray_dir_z_out = res_shown.dir_z;
endmodule
